// File: rtl/instr_mem_pipe_if.sv
// Fetch/response/program-load bundle for instr_mem_pipe.
// The master drives requests and loads; the slave is the instruction memory.
interface instr_mem_pipe_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_instr;
    logic              resp_fault;
    logic [ADDR_W-1:0] resp_addr;
    logic              flush;
    logic              load_en;
    logic [ADDR_W-1:0] load_addr;
    logic [DATA_W-1:0] load_data;

    modport master (
        output req_valid, req_addr, resp_ready, flush, load_en, load_addr, load_data,
        input  req_ready, resp_valid, resp_instr, resp_fault, resp_addr
    );

    modport slave (
        input  req_valid, req_addr, resp_ready, flush, load_en, load_addr, load_data,
        output req_ready, resp_valid, resp_instr, resp_fault, resp_addr
    );
endinterface

// File: rtl/instr_mem_pipe.sv
// Single-cycle-latency instruction memory with a one-entry response register.
// Define IMEM_BOUNDS_CHECK_EN to fault fetches and drop loads beyond the store.
module instr_mem_pipe #(
    parameter int DATA_W      = 32,
    parameter int DEPTH_WORDS = 256,
    parameter int ADDR_W      = 32
) (
    input logic              clk,
    input logic              rst,
    instr_mem_pipe_if.slave  bus
);
    localparam int BYTES = DATA_W / 8;
    localparam int OFF_B = $clog2(BYTES);
    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(BYTES - 1);

    // Store powers up zeroed and is deliberately untouched by rst.
    logic [DATA_W-1:0] mem [DEPTH_WORDS] = '{default: '0};

    logic              valid_q;
    logic [DATA_W-1:0] instr_q;
    logic              fault_q;
    logic [ADDR_W-1:0] addr_q;

    logic              handshake;
    logic [IDX_W-1:0]  rd_idx;
    logic [IDX_W-1:0]  wr_idx;
    logic              misaligned;
    logic              req_fault;
    logic              wr_ok;

    // Handshake: a request transfers when req_valid && req_ready; a response
    // transfers when resp_valid && resp_ready. req_ready = !resp_valid || resp_ready,
    // so the response slot is refilled in the same cycle it is drained.
    assign bus.req_ready = !valid_q || bus.resp_ready;
    assign handshake     = bus.req_valid && bus.req_ready;

    assign rd_idx     = IDX_W'(bus.req_addr >> OFF_B);
    assign wr_idx     = IDX_W'(bus.load_addr >> OFF_B);
    assign misaligned = |(bus.req_addr & OFF_MASK);

`ifdef IMEM_BOUNDS_CHECK_EN
    logic rd_oob;
    logic wr_oob;
    assign rd_oob    = (bus.req_addr >> (OFF_B + IDX_W)) != '0;
    assign wr_oob    = (bus.load_addr >> (OFF_B + IDX_W)) != '0;
    assign req_fault = misaligned || rd_oob;
    assign wr_ok     = !wr_oob;
`else
    assign req_fault = misaligned;
    assign wr_ok     = 1'b1;
`endif

    // Stored words are little-endian: byte 0 of the instruction sits in bits [7:0].
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            instr_q <= '0;
            fault_q <= 1'b0;
            addr_q  <= '0;
        end else if (handshake) begin
            valid_q <= 1'b1;
            instr_q <= req_fault ? '0 : mem[rd_idx];
            fault_q <= req_fault;
            addr_q  <= bus.req_addr;
        end else if (bus.flush || bus.resp_ready) begin
            valid_q <= 1'b0;
        end
    end

    // Read above samples the old word, so a same-cycle load is read-before-write.
    always_ff @(posedge clk) begin
        if (!rst && bus.load_en && wr_ok) begin
            mem[wr_idx] <= bus.load_data;
        end
    end

    assign bus.resp_valid = valid_q;
    assign bus.resp_instr = instr_q;
    assign bus.resp_fault = fault_q;
    assign bus.resp_addr  = addr_q;
endmodule

// File: tb/tb_instr_mem_pipe.sv
// Directed vector bench for instr_mem_pipe: one vector per clock cycle,
// followed by a hand-written reset-in-flight sequence.
module tb_instr_mem_pipe;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    instr_mem_pipe_if #(.DATA_W(32), .ADDR_W(32)) bus ();

    instr_mem_pipe #(.DATA_W(32), .DEPTH_WORDS(256), .ADDR_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        rv;
        logic [31:0] ra;
        logic        rr;
        logic        fl;
        logic        le;
        logic [31:0] la;
        logic [31:0] ld;
        logic        e_rdy;
        logic        e_v;
        logic [31:0] e_i;
        logic        e_f;
        logic [31:0] e_a;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic rv, logic [31:0] ra, logic rr, logic fl,
                                logic le, logic [31:0] la, logic [31:0] ld,
                                logic e_rdy, logic e_v, logic [31:0] e_i,
                                logic e_f, logic [31:0] e_a);
        vec_t v;
        v.rv = rv; v.ra = ra; v.rr = rr; v.fl = fl;
        v.le = le; v.la = la; v.ld = ld;
        v.e_rdy = e_rdy; v.e_v = e_v; v.e_i = e_i; v.e_f = e_f; v.e_a = e_a;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    task automatic drive(input logic rv, input logic [31:0] ra, input logic rr,
                         input logic fl, input logic le, input logic [31:0] la,
                         input logic [31:0] ld);
        bus.req_valid  = rv;
        bus.req_addr   = ra;
        bus.resp_ready = rr;
        bus.flush      = fl;
        bus.load_en    = le;
        bus.load_addr  = la;
        bus.load_data  = ld;
    endtask

    // Drive at edge+1, check req_ready mid-cycle, check registered outputs at next edge+1.
    task automatic apply(input vec_t v, input int n);
        drive(v.rv, v.ra, v.rr, v.fl, v.le, v.la, v.ld);
        #2;
        check($sformatf("v%0d req_ready", n), 32'(bus.req_ready), 32'(v.e_rdy));
        @(posedge clk);
        #1;
        check($sformatf("v%0d resp_valid", n), 32'(bus.resp_valid), 32'(v.e_v));
        if (v.e_v) begin
            check($sformatf("v%0d resp_instr", n), bus.resp_instr, v.e_i);
            check($sformatf("v%0d resp_fault", n), 32'(bus.resp_fault), 32'(v.e_f));
            check($sformatf("v%0d resp_addr", n), bus.resp_addr, v.e_a);
        end
    endtask

    initial begin
        logic [31:0] w0x400_i;
        logic        w0x400_f;
        logic [31:0] w4_final;
`ifdef IMEM_BOUNDS_CHECK_EN
        w0x400_i = 32'h0;      w0x400_f = 1'b1;
        w4_final = 32'h77777777;
`else
        w0x400_i = 32'hE3A00014; w0x400_f = 1'b0;
        w4_final = 32'h99999999;
`endif
        //           rv  ra          rr  fl  le  la      ld             rdy v   instr         f   addr
        vecs.push_back(mk(1, 32'h20,  1, 0, 0, 32'h0,  32'h0,         1, 1, 32'h0,        0, 32'h20));
        vecs.push_back(mk(0, 32'h0,   1, 0, 1, 32'h0,  32'hE3A00014,  1, 0, 32'h0,        0, 32'h0));
        vecs.push_back(mk(0, 32'h0,   1, 0, 1, 32'h4,  32'h11111111,  1, 0, 32'h0,        0, 32'h0));
        vecs.push_back(mk(0, 32'h0,   1, 0, 1, 32'h8,  32'h22222222,  1, 0, 32'h0,        0, 32'h0));
        vecs.push_back(mk(0, 32'h0,   1, 0, 1, 32'hC,  32'h33333333,  1, 0, 32'h0,        0, 32'h0));
        vecs.push_back(mk(0, 32'h0,   1, 0, 1, 32'h10, 32'hA5A5A5A5,  1, 0, 32'h0,        0, 32'h0));
        vecs.push_back(mk(1, 32'h0,   1, 0, 0, 32'h0,  32'h0,         1, 1, 32'hE3A00014, 0, 32'h0));
        vecs.push_back(mk(1, 32'h4,   1, 0, 0, 32'h0,  32'h0,         1, 1, 32'h11111111, 0, 32'h4));
        vecs.push_back(mk(1, 32'h8,   0, 0, 0, 32'h0,  32'h0,         0, 1, 32'h11111111, 0, 32'h4));
        vecs.push_back(mk(1, 32'h8,   0, 0, 0, 32'h0,  32'h0,         0, 1, 32'h11111111, 0, 32'h4));
        vecs.push_back(mk(1, 32'h8,   0, 0, 0, 32'h0,  32'h0,         0, 1, 32'h11111111, 0, 32'h4));
        vecs.push_back(mk(1, 32'h8,   1, 0, 0, 32'h0,  32'h0,         1, 1, 32'h22222222, 0, 32'h8));
        vecs.push_back(mk(0, 32'h0,   1, 0, 0, 32'h0,  32'h0,         1, 0, 32'h0,        0, 32'h0));
        vecs.push_back(mk(1, 32'h2,   1, 0, 0, 32'h0,  32'h0,         1, 1, 32'h0,        1, 32'h2));
        vecs.push_back(mk(1, 32'h400, 1, 0, 0, 32'h0,  32'h0,         1, 1, w0x400_i,     w0x400_f, 32'h400));
        vecs.push_back(mk(1, 32'h4,   1, 0, 0, 32'h0,  32'h0,         1, 1, 32'h11111111, 0, 32'h4));
        vecs.push_back(mk(0, 32'h0,   0, 1, 0, 32'h0,  32'h0,         0, 0, 32'h0,        0, 32'h0));
        vecs.push_back(mk(1, 32'h8,   0, 0, 0, 32'h0,  32'h0,         1, 1, 32'h22222222, 0, 32'h8));
        vecs.push_back(mk(1, 32'hC,   1, 1, 0, 32'h0,  32'h0,         1, 1, 32'h33333333, 0, 32'hC));
        vecs.push_back(mk(0, 32'h0,   1, 0, 0, 32'h0,  32'h0,         1, 0, 32'h0,        0, 32'h0));
        vecs.push_back(mk(1, 32'h10,  1, 0, 1, 32'h10, 32'hDEADBEEF,  1, 1, 32'hA5A5A5A5, 0, 32'h10));
        vecs.push_back(mk(1, 32'h10,  1, 0, 0, 32'h0,  32'h0,         1, 1, 32'hDEADBEEF, 0, 32'h10));
        vecs.push_back(mk(0, 32'h0,   1, 0, 1, 32'h5,  32'h77777777,  1, 0, 32'h0,        0, 32'h0));
        vecs.push_back(mk(1, 32'h4,   1, 0, 0, 32'h0,  32'h0,         1, 1, 32'h77777777, 0, 32'h4));
        vecs.push_back(mk(0, 32'h0,   1, 0, 1, 32'h404, 32'h99999999, 1, 0, 32'h0,        0, 32'h0));
        vecs.push_back(mk(1, 32'h4,   1, 0, 0, 32'h0,  32'h0,         1, 1, w4_final,     0, 32'h4));
        vecs.push_back(mk(1, 32'h8,   0, 0, 0, 32'h0,  32'h0,         0, 1, w4_final,     0, 32'h4));

        // Reset block: hold rst for two cycles with live-looking inputs.
        drive(1, 32'h4, 1, 0, 1, 32'h0, 32'hFFFFFFFF);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset resp_valid", 32'(bus.resp_valid), 32'h0);
        check("reset resp_instr", bus.resp_instr, 32'h0);
        check("reset resp_fault", 32'(bus.resp_fault), 32'h0);
        check("reset resp_addr",  bus.resp_addr, 32'h0);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], i);
        end

        // Reset while a response is held; the load during reset must be ignored.
        drive(1, 32'h8, 0, 0, 1, 32'h0, 32'hBAD0BAD0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst resp_valid", 32'(bus.resp_valid), 32'h0);
        check("midrst resp_instr", bus.resp_instr, 32'h0);
        check("midrst resp_fault", 32'(bus.resp_fault), 32'h0);
        check("midrst resp_addr",  bus.resp_addr, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(1, 32'h0, 1, 0, 0, 32'h0, 32'h0);
        #2;
        check("postrst req_ready", 32'(bus.req_ready), 32'h1);
        @(posedge clk);
        #1;
        check("postrst resp_valid", 32'(bus.resp_valid), 32'h1);
        check("postrst word0",      bus.resp_instr, 32'hE3A00014);
        drive(1, 32'h10, 1, 0, 0, 32'h0, 32'h0);
        @(posedge clk);
        #1;
        check("postrst word10", bus.resp_instr, 32'hDEADBEEF);
        check("postrst addr10", bus.resp_addr, 32'h10);
        drive(0, 32'h0, 1, 0, 0, 32'h0, 32'h0);
        @(posedge clk);
        #1;
        check("postrst drain", 32'(bus.resp_valid), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end
endmodule

// File: doc/instr_mem_pipe.md
INSTR_MEM_PIPE -- requirements
Module: instr_mem_pipe

Interface
REQ-001 SHALL have parameter DATA_W, default 32, instruction width in bits; multiple of 8.
REQ-002 SHALL have parameter DEPTH_WORDS, default 256, number of instruction words stored; power of two, at least 2.
REQ-003 SHALL have parameter ADDR_W, default 32, byte-address width.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-006 SHALL have port req_valid, input, 1 bit: fetch request present.
REQ-007 SHALL have port req_ready, output, 1 bit: fetch request accepted this cycle.
REQ-008 SHALL have port req_addr, input, ADDR_W bits: byte address of the instruction.
REQ-009 SHALL have port resp_valid, output, 1 bit: resp_instr and resp_fault are valid.
REQ-010 SHALL have port resp_ready, input, 1 bit: consumer takes the response.
REQ-011 SHALL have port resp_instr, output, DATA_W bits: fetched instruction, little-endian byte assembly.
REQ-012 SHALL have port resp_fault, output, 1 bit: request was misaligned or out of range.
REQ-013 SHALL have port resp_addr, output, ADDR_W bits: echo of the accepted req_addr.
REQ-014 SHALL have port flush, input, 1 bit: discard the response held or in flight (branch taken).
REQ-015 SHALL have port load_en, input, 1 bit: program-load write strobe.
REQ-016 SHALL have port load_addr, input, ADDR_W bits: byte address of the word being written.
REQ-017 SHALL have port load_data, input, DATA_W bits: word to write.

Function
REQ-018 SHALL store DEPTH_WORDS words; the word index is req_addr[log2(DEPTH_WORDS)+log2(DATA_W/8)-1 : log2(DATA_W/8)].
REQ-019 SHALL assemble resp_instr with byte 0 = bits [7:0] (lowest address in the least-significant byte).
REQ-020 SHALL drive req_ready = !resp_valid || resp_ready, combinationally, with flush having no effect on req_ready.
REQ-021 SHALL, on a handshake (req_valid && req_ready), register the word, req_addr and fault into the response register; resp_valid is high the next cycle (latency 1).
REQ-022 SHALL hold resp_instr, resp_addr and resp_fault stable while resp_valid && !resp_ready.
REQ-023 SHALL clear resp_valid after a cycle with resp_ready high and no new handshake.
REQ-024 SHALL, on flush, clear resp_valid next cycle; if a handshake occurs in the same cycle, the new request wins and resp_valid is 1 next cycle with the new data.
REQ-025 SHALL raise resp_fault for req_addr with any nonzero bit in [log2(DATA_W/8)-1:0]; resp_instr is then all zeros.
REQ-026 SHALL write load_data to the addressed word on load_en, ignoring byte-offset bits; loads are permitted while fetches run.
REQ-027 SHALL, when a load and a fetch target the same word in the same cycle, return the old word (read-before-write); the next fetch returns the new word.
REQ-028 SHALL power up the store with all words zero; the store contents are not cleared by rst.

Reset
REQ-029 SHALL, while rst is high, force resp_valid=0, resp_fault=0, resp_instr=0 and resp_addr=0, and ignore req_valid and load_en.
REQ-030 SHALL drop any response in flight when rst is asserted mid-operation; the first handshake is possible in the first cycle after rst falls.

Configuration
REQ-031 SHALL, with IMEM_BOUNDS_CHECK_EN defined, raise resp_fault (resp_instr=0) for aligned addresses at or above DEPTH_WORDS*(DATA_W/8), and ignore loads to such addresses.
REQ-032 SHALL, without IMEM_BOUNDS_CHECK_EN, wrap out-of-range addresses modulo the store size, with faults raised only for misalignment.

Verification
REQ-033 SHALL cover: load word 0xE3A00014 at 0x0, fetch 0x0 with resp_ready=1 -> resp_valid next cycle, resp_instr=0xE3A00014, resp_fault=0.
REQ-034 SHALL cover: back-to-back fetches 0x0,0x4,0x8 with resp_ready=0 on the second response for 3 cycles -> req_ready=0 and the response for 0x4 held stable, then 0x8 delivered with no loss or duplication.
REQ-035 SHALL cover: fetch 0x2 -> resp_fault=1, resp_instr=0; with IMEM_BOUNDS_CHECK_EN and defaults, fetch 0x400 -> resp_fault=1; without the macro, fetch 0x400 returns the word at 0x0.
REQ-036 SHALL cover: a held response with flush=1 and req_valid=0 -> resp_valid=0 next cycle; flush=1 with a new request to 0xC -> the response for 0xC is valid next cycle.
REQ-037 SHALL cover: same-cycle load 0xDEADBEEF and fetch at 0x10 -> the first fetch returns the old value and a refetch returns 0xDEADBEEF.
REQ-038 SHALL cover: rst asserted while resp_valid=1 -> all outputs zero next cycle, and stored words are preserved after reset.
